// File: rtl/axioma_constants.sv
// Shared register map, control-bit positions and capture FSM encodings
// for the axioma timer/capture family.
package axioma_constants;

  localparam int ADDR_W = 6;

  localparam logic [ADDR_W-1:0] ADDR_CAPFLG = 6'h16;
  localparam logic [ADDR_W-1:0] ADDR_CAPMSK = 6'h2F;
  localparam logic [ADDR_W-1:0] ADDR_CAPCR  = 6'h30;
  localparam logic [ADDR_W-1:0] ADDR_CNTL   = 6'h31;
  localparam logic [ADDR_W-1:0] ADDR_CNTH   = 6'h32;
  localparam logic [ADDR_W-1:0] ADDR_ICRL   = 6'h33;
  localparam logic [ADDR_W-1:0] ADDR_ICRH   = 6'h34;
  localparam logic [ADDR_W-1:0] ADDR_PWHL   = 6'h35;
  localparam logic [ADDR_W-1:0] ADDR_PWHH   = 6'h36;

  localparam int CAPCR_EN    = 0;
  localparam int CAPCR_CS_LO = 1;
  localparam int CAPCR_CS_HI = 3;
  localparam int CAPCR_ICES  = 4;
  localparam int CAPCR_ICNC  = 5;
  localparam int CAPCR_MODE  = 6;

  localparam int FLG_TOV  = 0;
  localparam int FLG_ICF  = 1;
  localparam int FLG_MISS = 2;

  localparam int MSK_TOIE = 0;
  localparam int MSK_ICIE = 1;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_HIGH       = 2'd1,
    ST_LOW        = 2'd2
  } cap_state_t;

endpackage

// File: rtl/axioma_pwm_capture_if.sv
// Byte-wide CPU I/O port used by the capture unit.
interface axioma_pwm_capture_if;
  import axioma_constants::*;

  logic [ADDR_W-1:0] io_addr;
  logic [7:0]        io_data_in;
  logic [7:0]        io_data_out;
  logic              io_read;
  logic              io_write;

  modport master (output io_addr, io_data_in, io_read, io_write, input io_data_out);
  modport slave  (input io_addr, io_data_in, io_read, io_write, output io_data_out);
endinterface

// File: rtl/axioma_prescaler.sv
// Common clock-select prescaler: CS 001=clk, 010=/8, 011=/64, 100=/256,
// 101=/1024, anything else stops the tick.
module axioma_prescaler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] cs,
  output logic       tick
);

  logic [9:0] div_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_q + 10'd1;
  end

  always_comb begin
    tick = 1'b0;
    case (cs)
      3'b001:  tick = 1'b1;
      3'b010:  tick = (div_q[2:0] == 3'd0);
      3'b011:  tick = (div_q[5:0] == 6'd0);
      3'b100:  tick = (div_q[7:0] == 8'd0);
      3'b101:  tick = (div_q == 10'd0);
      default: tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/axioma_pwm_capture.sv
// Input-capture unit: 16-bit timebase, filtered capture pin, timestamp or
// pulse-width/period measurement, byte-wide register file with shared TEMP.
module axioma_pwm_capture
  import axioma_constants::*;
#(
  parameter int ICNC_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  axioma_pwm_capture_if.slave  bus,
  input  logic                 icp_pin,
  output logic                 capture_irq,
  output logic                 overflow_irq,
  output logic [15:0]          debug_cnt,
  output logic [1:0]           debug_state
);

  localparam int EQ_W = (ICNC_DEPTH > 1) ? $clog2(ICNC_DEPTH) : 1;
  localparam logic [EQ_W-1:0] EQ_LAST = EQ_W'(ICNC_DEPTH - 1);

  // Differences wrap modulo 2^16, valid across at most one counter wrap.
  function automatic logic [15:0] stamp_diff(input logic [15:0] now, input logic [15:0] then_v);
    return now - then_v;
  endfunction

  logic [ADDR_W-1:0] addr;
  logic [7:0]  wdata, rdata, temp_q;
  logic [6:0]  capcr_q;
  logic [1:0]  capmsk_q;
  logic [2:0]  capflg_q, flg_set, flg_clr;
  logic [15:0] cnt_q, icr_q, pwh_q, rise_q;
  logic        en, ices, icnc, mode, tick, cnt_tick, tov_set;
  logic        wr_capcr, wr_capmsk, wr_capflg, wr_cntl, wr_cnth;
  logic        rd_cntl, rd_icrl, rd_pwhl;
  logic        sync_p0, sync_p1, filt_q, level_p1, level_p2, rise, fall;
  logic [EQ_W-1:0] eq_cnt_q;
  logic        cap_ts, stamp_ld, pwh_ld, per_ld, icr_ld;
  cap_state_t  state_q, state_d;

  assign addr  = bus.io_addr;
  assign wdata = bus.io_data_in;
  assign en    = capcr_q[CAPCR_EN];
  assign ices  = capcr_q[CAPCR_ICES];
  assign icnc  = capcr_q[CAPCR_ICNC];
  assign mode  = capcr_q[CAPCR_MODE];

  assign wr_capcr  = bus.io_write && (addr == ADDR_CAPCR);
  assign wr_capmsk = bus.io_write && (addr == ADDR_CAPMSK);
  assign wr_capflg = bus.io_write && (addr == ADDR_CAPFLG);
  assign wr_cntl   = bus.io_write && (addr == ADDR_CNTL);
  assign wr_cnth   = bus.io_write && (addr == ADDR_CNTH);
  assign rd_cntl   = bus.io_read  && (addr == ADDR_CNTL);
  assign rd_icrl   = bus.io_read  && (addr == ADDR_ICRL);
  assign rd_pwhl   = bus.io_read  && (addr == ADDR_PWHL);

  axioma_prescaler u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (capcr_q[CAPCR_CS_HI:CAPCR_CS_LO]),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capcr_q  <= '0;
      capmsk_q <= '0;
      temp_q   <= '0;
    end else begin
      if (wr_capcr)  capcr_q  <= wdata[6:0];
      if (wr_capmsk) capmsk_q <= wdata[1:0];
      if (rd_cntl)      temp_q <= cnt_q[15:8];
      else if (rd_icrl) temp_q <= icr_q[15:8];
      else if (rd_pwhl) temp_q <= pwh_q[15:8];
      else if (wr_cnth) temp_q <= wdata;
    end
  end

  // p0/p1: two-flop synchronizer; filter counts consecutive samples that disagree with filt_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      filt_q   <= 1'b0;
      eq_cnt_q <= '0;
      level_p2 <= 1'b0;
    end else begin
      sync_p0  <= icp_pin;
      sync_p1  <= sync_p0;
      level_p2 <= level_p1;
      if (sync_p1 == filt_q) begin
        eq_cnt_q <= '0;
      end else if (eq_cnt_q == EQ_LAST) begin
        filt_q   <= sync_p1;
        eq_cnt_q <= '0;
      end else begin
        eq_cnt_q <= eq_cnt_q + EQ_W'(1);
      end
    end
  end

  // p1 -> p2: edge detect against the previous filtered level.
  assign level_p1 = icnc ? filt_q : sync_p1;
  assign rise     = level_p1 & ~level_p2;
  assign fall     = ~level_p1 & level_p2;
  assign cap_ts   = en & ~mode & (ices ? rise : fall);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_WAIT_FIRST;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stamp_ld = 1'b0;
    pwh_ld   = 1'b0;
    per_ld   = 1'b0;
    if (!en || !mode || wr_capcr) begin
      state_d = ST_WAIT_FIRST;
    end else begin
      case (state_q)
        ST_WAIT_FIRST: if (rise) begin state_d = ST_HIGH; stamp_ld = 1'b1; end
        ST_HIGH:       if (fall) begin state_d = ST_LOW;  pwh_ld   = 1'b1; end
        ST_LOW:        if (rise) begin state_d = ST_HIGH; stamp_ld = 1'b1; per_ld = 1'b1; end
        default:       state_d = ST_WAIT_FIRST;
      endcase
    end
  end

  assign icr_ld   = cap_ts | per_ld;
  assign cnt_tick = en & tick;
  assign tov_set  = cnt_tick & (cnt_q == 16'hFFFF) & ~wr_cntl;
  assign flg_set  = {icr_ld & capflg_q[FLG_ICF], icr_ld, tov_set};
  assign flg_clr  = wr_capflg ? wdata[2:0] : 3'b000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      icr_q    <= '0;
      pwh_q    <= '0;
      rise_q   <= '0;
      capflg_q <= '0;
    end else begin
      if (wr_cntl)       cnt_q <= {temp_q, wdata};
      else if (cnt_tick) cnt_q <= cnt_q + 16'd1;
      if (icr_ld)   icr_q  <= per_ld ? stamp_diff(cnt_q, rise_q) : cnt_q;
      if (pwh_ld)   pwh_q  <= stamp_diff(cnt_q, rise_q);
      if (stamp_ld) rise_q <= cnt_q;
      capflg_q <= (capflg_q & ~flg_clr) | flg_set;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (bus.io_read) begin
      case (addr)
        ADDR_CAPCR:  rdata = {1'b0, capcr_q};
        ADDR_CNTL:   rdata = cnt_q[7:0];
        ADDR_CNTH:   rdata = temp_q;
        ADDR_ICRL:   rdata = icr_q[7:0];
        ADDR_ICRH:   rdata = temp_q;
        ADDR_PWHL:   rdata = pwh_q[7:0];
        ADDR_PWHH:   rdata = temp_q;
        ADDR_CAPMSK: rdata = {6'b0, capmsk_q};
        ADDR_CAPFLG: rdata = {5'b0, capflg_q};
        default:     rdata = 8'h00;
      endcase
    end
  end

  assign bus.io_data_out = rdata;
  assign capture_irq     = capflg_q[FLG_ICF] & capmsk_q[MSK_ICIE];
  assign overflow_irq    = capflg_q[FLG_TOV] & capmsk_q[MSK_TOIE];
  assign debug_cnt       = cnt_q;
  assign debug_state     = state_q;

endmodule

// File: doc/axioma_pwm_capture.md
AXIOMA_PWM_CAPTURE -- requirements
Module: axioma_pwm_capture

Interface
REQ-001 SHALL have parameter ICNC_DEPTH, default 4, number of consecutive equal samples the noise canceler requires.
REQ-002 SHALL have ports: clk  input  1  system clock; reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: io_addr  input  6  I/O address; io_data_in  input  8  write data; io_data_out  output  8  read data; io_read  input  1  read strobe; io_write  input  1  write strobe.
REQ-004 SHALL have ports: icp_pin  input  1  asynchronous capture input, normally fed from another timer's PWM output.
REQ-005 SHALL have ports: capture_irq  output  1  ICF & ICIE; overflow_irq  output  1  TOV & TOIE.
REQ-006 SHALL have ports: debug_cnt  output  16  live counter; debug_state  output  2  FSM state.

Function
REQ-007 SHALL decode the registers CAPCR 0x30, CNTL 0x31, CNTH 0x32, ICRL 0x33, ICRH 0x34, PWHL 0x35, PWHH 0x36, CAPMSK 0x2F, CAPFLG 0x16; other addresses SHALL read 0x00 and ignore writes.
REQ-008 SHALL map CAPCR as: [0] EN, [3:1] CS, [4] ICES (1 = rising), [5] ICNC, [6] MODE (0 = timestamp, 1 = pulse), [7] reserved (reads 0).
REQ-009 SHALL map CAPFLG as: [0] TOV, [1] ICF, [2] MISS, and CAPMSK as: [0] TOIE, [1] ICIE; upper bits SHALL read 0.
REQ-010 SHALL clear a flag when the CPU writes 1 to its CAPFLG bit; a hardware set in the same cycle SHALL win.
REQ-011 SHALL increment the 16-bit counter by 1 on each prescaler tick while EN=1, wrap 0xFFFF->0x0000, and set TOV on that wrap.
REQ-012 SHALL hold the counter while EN=0; a CPU write to the counter SHALL take precedence over a same-cycle tick.
REQ-013 SHALL synchronize icp_pin through 2 flops; with ICNC=1 the filtered level SHALL change only after ICNC_DEPTH consecutive equal synchronized samples; with ICNC=0 it SHALL equal the synchronized level.
REQ-014 SHALL detect edges on the filtered level one cycle after it changes; pin-to-capture latency SHALL be 3 clk with ICNC=0 and 3+ICNC_DEPTH clk with ICNC=1.
REQ-015 SHALL, in MODE=0, load ICR with the counter value of the edge-detect cycle on each ICES-selected edge and set ICF.
REQ-016 SHALL, in MODE=1, run the FSM WAIT_FIRST -> HIGH (first rising edge; store rise stamp, no ICF) -> LOW (falling edge; PWH = cnt - rise stamp) -> HIGH (rising edge; ICR = cnt - rise stamp, new rise stamp, set ICF).
REQ-017 SHALL ignore falling edges in WAIT_FIRST and HIGH-state rising edges (impossible with a filtered level, but they SHALL not corrupt state); ICES SHALL be ignored in MODE=1.
REQ-018 SHALL compute differences modulo 2^16, which is correct for at most one counter wrap between edges.
REQ-019 SHALL set MISS when a capture sets ICF while ICF is already 1; ICR SHALL still be overwritten.
REQ-020 SHALL force the FSM to WAIT_FIRST whenever EN=0 or MODE is written.
REQ-021 SHALL perform 16-bit accesses through one shared TEMP byte: reading any L byte latches its H byte into TEMP; reading any H byte returns TEMP; writing CNTH stores TEMP; writing CNTL commits {TEMP, data} atomically.
REQ-022 SHALL treat ICR and PWH as read-only.
REQ-023 SHALL produce io_data_out combinationally, 0x00 when io_read=0.

Reset
REQ-024 SHALL asynchronously clear all registers, TEMP, the counter, the rise stamp, and the filter history and set the FSM to WAIT_FIRST; all outputs SHALL be 0 and the filtered level SHALL be 0 during reset.
REQ-025 SHALL, when reset is applied mid-measurement, discard the partial measurement with no flag set on release.

Structure
REQ-026 SHALL place register addresses, CAPCR bit positions, and FSM state encodings in the shared axioma_constants package.
REQ-027 SHALL instantiate the common axioma_prescaler (CS -> tick) as its only sub-module.

Verification
REQ-028 Directed tests SHALL cover:
- MODE=0, ICES=1, CS=001, CNT written 0x1234, rising edge -> ICR = 0x1234 + 3, ICF=1, capture_irq=1 iff ICIE=1.
- MODE=1, CS=001, timer0 PWM period 256 clk, high 64 clk -> after the second rising edge ICR=0x0100, PWH=0x0040.
- CNT=0xFFFE, two ticks -> CNT=0x0000, TOV=1; write CAPFLG=0x01 in the TOV-set cycle -> TOV stays 1.
- ICNC=1, 3-clk glitch on icp_pin -> no ICF; 4-clk stable pulse -> capture 7 clk after the pin edge.
- Two captures without clearing ICF -> MISS=1 and ICR holds the second value.
- Read CNTL, let the counter tick past 0x00FF->0x0100, read CNTH -> returns the high byte latched at the CNTL read; reset asserted mid-pulse -> FSM in WAIT_FIRST, flags 0.
